// File: rtl/differentiator_pkg.sv
// rtl/differentiator_pkg.sv - shared limits, sample type and index-width helper for the differentiator
package differentiator_pkg;

  localparam int MAX_CHANNELS  = 16;
  localparam int MAX_LAG       = 16;
  localparam int DEFAULT_WIDTH = 16;

  // Signed phase/frequency word at the default sample width.
  typedef logic signed [DEFAULT_WIDTH-1:0] sample_t;

  // Width of a channel index; at least one bit so a single channel still has a port.
  function automatic int ch_index_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/delay_ring.sv
// rtl/delay_ring.sv - circular history buffer, read-old/write-new per strobe, pointer force-to-zero
module delay_ring #(
  parameter int width = 16,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             zero_ptr,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [AW-1:0] LAST = AW'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    addr;

  // A resync redirects this access to slot 0 without touching stored history.
  assign addr  = zero_ptr ? '0 : wp;
  assign rdata = mem[addr];

  // Store the new word where the old one was read, then advance the pointer with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[addr] <= wdata;
      wp        <= (addr == LAST) ? '0 : addr + AW'(1);
    end
  end

endmodule

// File: rtl/multichannel_differentiator.sv
// rtl/multichannel_differentiator.sv - per-channel out = in - in[lag back]; option MULTICHANNEL_DIFFERENTIATOR_PRIME_EN
module multichannel_differentiator
  import differentiator_pkg::*;
#(
  parameter int width    = 16,
  parameter int channels = 2,
  parameter int lag      = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic                                  in_first,
  input  logic signed [width-1:0]               in,
  output logic signed [width-1:0]               out,
  output logic                                  out_valid,
  output logic [ch_index_width(channels)-1:0]   out_ch,
  output logic                                  sync_err
);

  localparam int DEPTH = channels * lag;
  localparam int CW    = ch_index_width(channels);
  localparam logic [CW-1:0] CH_LAST = CW'(channels - 1);

  if (channels < 1 || channels > MAX_CHANNELS || lag < 1 || lag > MAX_LAG) begin : g_range_check
    $error("multichannel_differentiator: channels or lag out of range");
  end

  logic [CW-1:0]    ch;
  logic [CW-1:0]    ch_eff;
  logic             resync;
  logic             primed;
  logic [width-1:0] old_word;
  logic [width-1:0] diff;

  // A frame marker off the channel-0 slot realigns the stream to channel 0 / address 0.
  always_comb begin
    resync = en && in_first && (ch != '0);
    ch_eff = resync ? '0 : ch;
    diff   = in - old_word;
  end

  delay_ring #(
    .width (width),
    .depth (DEPTH)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .zero_ptr (resync),
    .wdata    (in),
    .rdata    (old_word)
  );

`ifdef MULTICHANNEL_DIFFERENTIATOR_PRIME_EN
  localparam int KW = $clog2(lag + 1);
  localparam logic [KW-1:0] CNT_FULL = KW'(lag);

  logic [KW-1:0] cnt [channels];

  // Output is trusted only once this channel has lag real samples behind it.
  assign primed = !resync && (cnt[ch] == CNT_FULL);

  // Saturating per-channel fill counters; a resync restarts priming on every channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < channels; c++) begin
        cnt[c] <= '0;
      end
    end else if (en) begin
      if (resync) begin
        for (int c = 0; c < channels; c++) begin
          cnt[c] <= '0;
        end
        cnt[0] <= KW'(1);
      end else if (cnt[ch] != CNT_FULL) begin
        cnt[ch] <= cnt[ch] + KW'(1);
      end
    end
  end
`else
  assign primed = 1'b1;
`endif

  // Register the difference, its channel tag and the sticky alignment error.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      sync_err  <= 1'b0;
      ch        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (en) begin
        out       <= diff;
        out_ch    <= ch_eff;
        out_valid <= primed;
        ch        <= (ch_eff == CH_LAST) ? '0 : ch_eff + CW'(1);
        if (resync) begin
          sync_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multichannel_differentiator.sv
// tb/tb_multichannel_differentiator.sv - vector table plus randomized model check of multichannel_differentiator
module tb_multichannel_differentiator;

`ifdef MULTICHANNEL_DIFFERENTIATOR_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               en   [4];
  logic               fst  [4];
  logic signed [15:0] din  [4];
  logic signed [15:0] dout [4];
  logic               vld  [4];
  logic               serr [4];
  logic [0:0]         och  [4];

  int lag_of [4] = '{1, 1, 4, 2};
  int chn_of [4] = '{1, 2, 1, 2};

  multichannel_differentiator #(.width(16), .channels(1), .lag(1)) u0 (
    .clk(clk), .reset(reset), .en(en[0]), .in_first(fst[0]), .in(din[0]),
    .out(dout[0]), .out_valid(vld[0]), .out_ch(och[0]), .sync_err(serr[0]));
  multichannel_differentiator #(.width(16), .channels(2), .lag(1)) u1 (
    .clk(clk), .reset(reset), .en(en[1]), .in_first(fst[1]), .in(din[1]),
    .out(dout[1]), .out_valid(vld[1]), .out_ch(och[1]), .sync_err(serr[1]));
  multichannel_differentiator #(.width(16), .channels(1), .lag(4)) u2 (
    .clk(clk), .reset(reset), .en(en[2]), .in_first(fst[2]), .in(din[2]),
    .out(dout[2]), .out_valid(vld[2]), .out_ch(och[2]), .sync_err(serr[2]));
  multichannel_differentiator #(.width(16), .channels(2), .lag(2)) u3 (
    .clk(clk), .reset(reset), .en(en[3]), .in_first(fst[3]), .in(din[3]),
    .out(dout[3]), .out_valid(vld[3]), .out_ch(och[3]), .sync_err(serr[3]));

  typedef struct {
    int k;
    bit rst;
    bit e;
    bit f;
    int d;
    int eout;
    int ech;
    int nth;
    bit eserr;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  task automatic add(int k, bit rst, bit e, bit f, int d, int eo, int ec, int n, bit es);
    vec_t v;
    v.k = k; v.rst = rst; v.e = e; v.f = f; v.d = d;
    v.eout = eo; v.ech = ec; v.nth = n; v.eserr = es;
    tbl.push_back(v);
  endtask

  task automatic drive(int k, bit r, bit e, bit f, int d);
    reset = r;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; fst[i] = 1'b0; din[i] = '0;
    end
    en[k]  = e;
    fst[k] = f;
    din[k] = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  shortint hq [4][2][$];
  int      mch [4];

  initial begin
    bit ev;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; fst[i] = 1'b0; din[i] = '0;
    end

    // k, rst, en, first, in, out, out_ch, nth-in-channel, sync_err
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 100, 100, 0, 0, 0);
    add(0, 0, 1, 0, 150, 50, 0, 1, 0);
    add(0, 0, 1, 1, 140, -10, 0, 2, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32760, 32760, 0, 0, 0);
    add(0, 0, 1, 0, -32760, 16, 0, 1, 0);
    add(1, 0, 1, 1, 10, 10, 0, 0, 0);
    add(1, 0, 1, 0, 100, 100, 1, 0, 0);
    add(1, 0, 1, 0, 20, 10, 0, 1, 0);
    add(1, 0, 1, 0, 70, -30, 1, 1, 0);
    for (int i = 0; i < 6; i++) add(2, 0, 1, (i == 0), 5 * i, (i < 4) ? 5 * i : 20, 0, i, 0);
    for (int i = 0; i < 3; i++) add(2, 0, 0, 0, 999, 20, 0, 0, 0);
    for (int i = 6; i < 10; i++) add(2, 0, 1, 0, 5 * i, 20, 0, i, 0);
    add(3, 0, 1, 1, 1, 1, 0, 0, 0);
    add(3, 0, 1, 0, 2, 2, 1, 0, 0);
    add(3, 0, 1, 0, 3, 3, 0, 1, 0);
    add(3, 0, 1, 0, 4, 4, 1, 1, 0);
    add(3, 0, 1, 1, 5, 4, 0, 2, 0);
    add(3, 0, 1, 0, 6, 4, 1, 2, 0);
    add(3, 0, 1, 0, 7, 4, 0, 3, 0);
    add(3, 0, 1, 1, 10, 5, 0, 0, 1);
    add(3, 0, 1, 0, 11, 5, 1, 0, 1);
    add(3, 0, 1, 0, 12, 5, 0, 1, 1);
    add(3, 0, 1, 0, 13, 9, 1, 1, 1);
    add(3, 0, 1, 0, 14, 4, 0, 2, 1);
    add(1, 0, 1, 0, 30, 10, 0, 2, 0);
    add(1, 0, 1, 1, 50, 20, 0, 0, 1);
    add(1, 0, 1, 0, 60, -10, 1, 0, 1);
    add(1, 0, 0, 1, 77, -10, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].k, tbl[i].rst, tbl[i].e, tbl[i].f, tbl[i].d);
      ev = !tbl[i].rst && tbl[i].e && (!PRIME || tbl[i].nth >= lag_of[tbl[i].k]);
      chk($sformatf("vec%0d.out", i), int'(dout[tbl[i].k]), tbl[i].eout);
      chk($sformatf("vec%0d.out_valid", i), int'(vld[tbl[i].k]), int'(ev));
      chk($sformatf("vec%0d.out_ch", i), int'(och[tbl[i].k]), tbl[i].ech);
      chk($sformatf("vec%0d.sync_err", i), int'(serr[tbl[i].k]), int'(tbl[i].eserr));
    end

    // Randomized stream on the two-channel instances against a per-channel sample history.
    drive(0, 1, 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      mch[a] = 0;
      for (int b = 0; b < 2; b++) hq[a][b].delete();
    end
    for (int it = 0; it < 600; it++) begin
      int k, c, n, lg;
      bit e, f;
      shortint ds, old, eo;
      k  = (it % 2 == 0) ? 3 : 1;
      e  = ($urandom_range(0, 9) < 7);
      ds = shortint'($urandom);
      if (e) f = (mch[k] == 0) && ($urandom_range(0, 1) == 1);
      else   f = ($urandom_range(0, 1) == 1);
      drive(k, 0, e, f, int'(ds));
      if (e) begin
        c   = mch[k];
        lg  = lag_of[k];
        n   = hq[k][c].size();
        old = (n >= lg) ? hq[k][c][n - lg] : 16'sd0;
        eo  = shortint'(int'(ds) - int'(old));
        ev  = !PRIME || (n >= lg);
        hq[k][c].push_back(ds);
        mch[k] = (c + 1) % chn_of[k];
        chk($sformatf("rnd%0d.out", it), int'(dout[k]), int'(eo));
        chk($sformatf("rnd%0d.out_ch", it), int'(och[k]), c);
      end else begin
        ev = 1'b0;
      end
      chk($sformatf("rnd%0d.out_valid", it), int'(vld[k]), int'(ev));
      chk($sformatf("rnd%0d.sync_err", it), int'(serr[k]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
